tt_sweep: RTL
=============

# tt_sweep

Sequential truth-table sweeper for the 4-input combinational stages in this problem-set design. It sits directly upstream of a 4-input/1-output block such as the SOP `source` stage (t = rs' + pq'r's). It drives that block's p, q, r, s inputs through all 16 combinations, lets the output settle, and samples t back. It builds a 16-bit truth-table word and a ones count, and compares the word against an expected table, so a single start pulse yields pass/fail for the stage under test.

## Interface
- `SETTLE`, default 1: extra hold cycles per vector before t is sampled; legal range 0..15.
- `EXPECTED`, default 16'h4644: expected table word; bit i = t for {p,q,r,s} = i. The default is the SOP stage's table: bits 2, 6, 9, 10 and 14 set.
- `clk`  in  1  system clock; rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  sweep request; sampled on the rising edge.
- `t`  in  1  output of the stage under test.
- `p`, `q`, `r`, `s`  out  1 each  stimulus vector; {p,q,r,s} = current index, p is the MSB.
- `busy`  out  1  sweep in progress.
- `done`  out  1  results valid; level signal.
- `table_out`  out  16  captured truth table; bit i = sampled t for index i.
- `ones_cnt`  out  5  number of 1s captured (0..16).
- `match`  out  1  table_out == EXPECTED; meaningful only while done = 1.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, start = 1 → RUN.
  - RUN, final sample taken → DONE.
  - DONE, start = 1 → RUN.
  - Any state, rst → IDLE.
- On start acceptance:
  - index ← 0, settle counter ← 0.
  - table_out ← 0, ones_cnt ← 0, done ← 0.
- RUN, per vector:
  - {p,q,r,s} = index, held for SETTLE+1 cycles.
  - Settle counter increments each cycle.
  - On the edge where the counter equals SETTLE: table_out[index] ← t, ones_cnt += t, counter ← 0.
  - After that sample: if index = 15 go to DONE, else index += 1.
- start is ignored while in RUN; there is no restart mid-sweep.
- DONE: {p,q,r,s} = 0000; table_out, ones_cnt and match are held until the next accepted start.
- match is combinational from table_out and EXPECTED, gated with done; it is 0 outside DONE.
- ones_cnt is 5 bits so that 16 ones cannot wrap.
- Reset mid-sweep: immediate (asynchronous) return to IDLE, partial results discarded.

## Timing
- Reset values: p = q = r = s = 0, busy = 0, done = 0, table_out = 0, ones_cnt = 0, match = 0.
- start accepted at edge E0:
  - From E0: busy = 1, vector 0000.
  - Vector k is driven from edge E0 + k·(SETTLE+1).
  - Vector k is sampled at edge E0 + (k+1)·(SETTLE+1).
- Final sample at edge E0 + 16·(SETTLE+1). At that same edge busy → 0 and done → 1.
  - SETTLE = 1: 32 cycles.
  - SETTLE = 0: 16 cycles, one vector per cycle.
- t must be stable SETTLE+1 cycles after its vector is applied. A purely combinational stage meets this with SETTLE = 0.
- Simultaneous start and rst: rst wins.
- start held high continuously: accepted again on the first DONE cycle, so sweeps run back-to-back with done high for exactly one cycle between them.

## Configuration
- `TT_SWEEP_MISMATCH_LOG_EN`: when defined, adds two outputs.
  - `first_miss` (out, 4): index of the lowest mismatching bit between table_out and EXPECTED.
  - `miss_valid` (out, 1): high when done = 1 and match = 0.
  - Both update at the final-sample edge and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Known-good stage: drive t = rs' + pq'r's from the SOP stage, SETTLE = 1, pulse start.
  - done after exactly 32 cycles.
  - table_out = 16'h4644, ones_cnt = 5, match = 1.
- Stuck-at: tie t = 1, SETTLE = 0.
  - done after 16 cycles.
  - table_out = 16'hFFFF, ones_cnt = 16, match = 0.
  - With the macro: first_miss = 0, miss_valid = 1.
- Fault at one index: model the stage with index 9 (1001) inverted.
  - table_out = 16'h4444, ones_cnt = 4, match = 0.
  - With the macro: first_miss = 9.
- Reset mid-sweep: assert rst during vector 7.
  - All outputs immediately at their reset values, state IDLE.
  - A new start then produces the full correct result.
- start pulsed again during RUN: ignored, completion time unchanged.
- start held high: back-to-back sweeps with done high for exactly 1 cycle between them, and table_out cleared at each restart.

Source files
------------

// File: rtl/tt_sweep_if.sv
// Bundle between the truth-table sweeper and the stage under test or its environment.
// When TT_SWEEP_MISMATCH_LOG_EN is defined the bundle also carries first_miss and miss_valid.
interface tt_sweep_if;
  logic        start;
  logic        t;
  logic        p;
  logic        q;
  logic        r;
  logic        s;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  ones_cnt;
  logic        match;
  logic [1:0]  fsm_state;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
  logic [3:0]  first_miss;
  logic        miss_valid;
`endif

  // start is a single-cycle request sampled on the rising edge; there is no
  // ready/acknowledge path. A start that arrives while busy=1 is dropped.
  // The results (table_out, ones_cnt, match) are qualified by the done level.
  modport master (
    output start, t,
    input  p, q, r, s, busy, done, table_out, ones_cnt, match, fsm_state
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    , input first_miss, miss_valid
`endif
  );

  modport slave (
    input  start, t,
    output p, q, r, s, busy, done, table_out, ones_cnt, match, fsm_state
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    , output first_miss, miss_valid
`endif
  );
endinterface

// File: rtl/tt_sweep.sv
// Sweeps a 4-input stage through all 16 vectors, samples t into a truth table and compares it.
// Optional mismatch logging (first_miss, miss_valid) is enabled by TT_SWEEP_MISMATCH_LOG_EN.
module tt_sweep #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h4644
) (
  input logic     clk,
  input logic     rst,
  tt_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] table_r;
  logic [4:0]  ones;
  logic        busy_r;
  logic        done_r;
  logic        start_ok;

  assign start_ok = bus.start && (state != RUN);

`ifdef TT_SWEEP_MISMATCH_LOG_EN
  logic [15:0] final_table;
  logic [15:0] miss_bits;
  logic [3:0]  fm_next;
  logic [3:0]  first_miss_r;
  logic        miss_valid_r;

  // The last sample lands in bit 15 on the same edge the log is captured.
  assign final_table = {bus.t, table_r[14:0]};
  assign miss_bits   = final_table ^ EXPECTED;

  always_comb begin
    fm_next = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (miss_bits[i]) fm_next = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_miss_r <= 4'd0;
      miss_valid_r <= 1'b0;
    end else if (start_ok) begin
      first_miss_r <= 4'd0;
      miss_valid_r <= 1'b0;
    end else if (state == RUN && cnt == SETTLE_C && idx == 4'd15) begin
      first_miss_r <= fm_next;
      miss_valid_r <= (final_table != EXPECTED);
    end
  end

  assign bus.first_miss = first_miss_r;
  assign bus.miss_valid = miss_valid_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      cnt     <= 4'd0;
      table_r <= 16'd0;
      ones    <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            idx     <= 4'd0;
            cnt     <= 4'd0;
            table_r <= 16'd0;
            ones    <= 5'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == SETTLE_C) begin
            table_r[idx] <= bus.t;
            ones         <= ones + {4'd0, bus.t};
            cnt          <= 4'd0;
            if (idx == 4'd15) begin
              // Vector returns to 0000 while results are held.
              state  <= DONE;
              idx    <= 4'd0;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p         = idx[3];
  assign bus.q         = idx[2];
  assign bus.r         = idx[1];
  assign bus.s         = idx[0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.table_out = table_r;
  assign bus.ones_cnt  = ones;
  assign bus.match     = done_r && (table_r == EXPECTED);
  assign bus.fsm_state = state;
endmodule
